// File: rtl/lock_arbiter_pkg.sv
// Shared types and defaults for the lock arbiter slice.
package lock_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_OPEN_CMD,
    ARB_WAIT_OPEN,
    ARB_GRANTED,
    ARB_CLOSE_CMD,
    ARB_WAIT_CLOSE
  } arb_state_e;

  localparam int unsigned N_REQ_DEFAULT    = 4;
  localparam int unsigned HOLD_MAX_DEFAULT = 16;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_arbiter_if.sv
// Request/grant bundle between the requesters and the lock arbiter, plus lock commands.
interface lock_arbiter_if
  import lock_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             open;
  logic             close;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req,
    input  grant, open, close, busy, timeout_err
  );

  modport slave (
    input  req,
    output grant, open, close, busy, timeout_err
  );

endinterface

// File: rtl/lock_arbiter_rr_picker.sv
// Round-robin first-set search over eligible requests, starting at rr_ptr and wrapping.
module lock_rr_picker
  import lock_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int PW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic             valid_o,
  output logic [PW-1:0]    idx_o
);

  int unsigned   pos;
  logic [PW-1:0] pos_idx;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos     = (32'(rr_ptr_i) + i) % N_REQ;
      pos_idx = PW'(pos);
      if (!valid_o && elig_i[pos_idx]) begin
        valid_o = 1'b1;
        idx_o   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/lock_arbiter.sv
// Shares one open/close lock among N_REQ requesters, tracking the lock's state
// from its fixed one-cycle command latencies since the lock reports no status.
module lock_arbiter
  import lock_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEFAULT,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  lock_arbiter_if.slave bus
);

  localparam int PW = idx_width(N_REQ);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] mask_q;
  logic [N_REQ-1:0] mask_d;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] owner_oh;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    rr_ptr_d;
  logic [PW-1:0]    owner_q;
  logic [PW-1:0]    pick_idx;
  logic [CW-1:0]    hold_cnt_q;
  logic             pick_valid;
  logic             owner_req;
  logic             timeout_hit;
  logic             open_q;
  logic             close_q;
  logic             busy_q;
  logic             timeout_q;

  lock_rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // A release on the HOLD_MAX cycle wins over the timeout: timeout needs req still high.
  always_comb begin
    elig        = bus.req & ~mask_q;
    owner_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    owner_req   = bus.req[owner_q];
    timeout_hit = (state_q == ARB_GRANTED) && owner_req && (hold_cnt_q == HOLD_LIM);
    rr_ptr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
    mask_d      = (mask_q & bus.req) | (timeout_hit ? owner_oh : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      open_q     <= 1'b0;
      close_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      open_q    <= 1'b0;
      close_q   <= 1'b0;
      timeout_q <= 1'b0;
      mask_q    <= mask_d;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_q  <= pick_idx;
            rr_ptr_q <= rr_ptr_d;
            open_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ARB_OPEN_CMD;
          end
        end
        ARB_OPEN_CMD: begin
          state_q <= ARB_WAIT_OPEN;
        end
        ARB_WAIT_OPEN: begin
          grant_q    <= owner_oh;
          hold_cnt_q <= CW'(1);
          state_q    <= ARB_GRANTED;
        end
        ARB_GRANTED: begin
          if (!owner_req || timeout_hit) begin
            grant_q   <= '0;
            close_q   <= 1'b1;
            timeout_q <= timeout_hit;
            state_q   <= ARB_CLOSE_CMD;
          end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
          end
        end
        ARB_CLOSE_CMD: begin
          hold_cnt_q <= '0;
          state_q    <= ARB_WAIT_CLOSE;
        end
        ARB_WAIT_CLOSE: begin
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.open        = open_q;
  assign bus.close       = close_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule
